irq_pending_latch: RTL and testbench
====================================

IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port req_in, input, 8 bits: raw request lines, synchronous to clk; bit 7 is the highest priority.
REQ-004 SHALL have port mask, input, 8 bits: a 1 blocks the corresponding pending bit from Y.
REQ-005 SHALL have port Y, output, 8 bits: the masked pending vector, fed directly into the downstream 8:3 priority encoder.
REQ-006 SHALL have port irq, output, 1 bit, registered: a serviceable request exists.
REQ-007 SHALL have port ack, input, 1 bit: one-cycle service acknowledge from the consumer.
REQ-008 SHALL have port ack_id, input, 3 bits: index being acknowledged, equal to the encoder's A output.
REQ-009 SHALL have port overrun_cnt, output, 4 bits: saturating count of lost events.

Function
REQ-010 SHALL hold an 8-bit pending register and an 8-bit registered copy req_q of req_in.
REQ-011 SHALL drive Y = pending AND NOT mask, combinationally, with zero-cycle latency from pending and mask.
REQ-012 SHALL set pending[i] at the clock edge on which req_in[i] is sampled as a rising edge (req_in[i]=1, req_q[i]=0), so the bit is visible in Y one cycle after req_in rises.
REQ-013 SHALL implement a state machine with states IDLE, ACTIVE and HOLDOFF, and drive irq=1 only in ACTIVE.
REQ-014 SHALL transition IDLE->ACTIVE on the edge where Y is nonzero; irq goes high the following cycle.
REQ-015 SHALL, in ACTIVE with ack=1, clear pending[ack_id] and transition to HOLDOFF.
REQ-016 SHALL transition ACTIVE->IDLE without an ack when Y becomes zero (mask raised), dropping irq the next cycle.
REQ-017 SHALL stay in HOLDOFF for exactly one cycle with irq=0, then go to IDLE, so the encoder output settles before the next service.
REQ-018 SHALL ignore ack in IDLE and HOLDOFF, with no pending change.
REQ-019 SHALL let set win when a set and an ack-clear hit the same bit in the same cycle: the bit stays 1 and the FSM still goes to HOLDOFF.
REQ-020 SHALL clear pending[ack_id] even if that bit is masked or already 0; no error is flagged.
REQ-021 SHALL increment overrun_cnt by 1 when a rising edge arrives on a bit already pending and not being cleared that cycle.
REQ-022 SHALL saturate overrun_cnt at 15, and SHALL add only 1 per cycle even when several bits overrun together.
REQ-023 SHALL leave pending unaffected by mask changes; unmasking an already-pending bit makes it appear in Y immediately.

Reset
REQ-024 SHALL, while rst=1 at an edge, force pending=0, overrun_cnt=0, state=IDLE and irq=0, so Y=0.
REQ-025 SHALL load req_q with req_in during reset, so lines held high through reset produce no event.
REQ-026 SHALL abandon any in-progress service when rst asserts mid-operation; no ack is required afterward.

Configuration
REQ-027 SHALL provide macro IRQ_EDGE_DETECT_EN.
REQ-028 SHALL, when IRQ_EDGE_DETECT_EN is defined, use the edge-triggered behaviour of REQ-012 and REQ-021.
REQ-029 SHALL, when IRQ_EDGE_DETECT_EN is undefined, use level mode:
- pending[i] is set on every edge where req_in[i]=1;
- set still wins over ack-clear;
- overrun_cnt is held at 0;
- req_q is not implemented.

Verification
REQ-030 SHALL cover single request: req_in=8'h04 from cycle 2 (edge mode) -> Y=8'h04 at cycle 3, irq=1 at cycle 4; ack=1, ack_id=2 -> Y=0, then one HOLDOFF cycle, then IDLE.
REQ-031 SHALL cover priority: req_in rises 8'h81 -> Y=8'h81; ack_id=7 -> Y=8'h01; after HOLDOFF, irq reasserts; ack_id=0 -> Y=0.
REQ-032 SHALL cover masking: pending=8'h10 in ACTIVE, mask=8'h10 -> Y=0, irq falls next cycle; mask=0 -> Y=8'h10 immediately, irq returns.
REQ-033 SHALL cover set/clear collision: new rising edge on bit 3 in the same cycle as ack with ack_id=3 -> pending[3]=1 after the edge.
REQ-034 SHALL cover overrun saturation: 20 pulses on bit 5 with no ack -> overrun_cnt=15, pending=8'h20.
REQ-035 SHALL cover reset mid-service: rst=1 for one cycle while ACTIVE with req_in=8'hFF held -> irq=0, Y=0, and no new events while req_in stays 8'hFF.

Source files
------------

// File: rtl/irq_pending_latch_if.sv
// rtl/irq_pending_latch_if.sv - request/mask/ack bus between the IRQ pending latch and its consumer
interface irq_pending_latch_if;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic [7:0] Y;
    logic       irq;
    logic       ack;
    logic [2:0] ack_id;
    logic [3:0] overrun_cnt;

    modport master (
        output req_in, mask, ack, ack_id,
        input  Y, irq, overrun_cnt
    );

    modport slave (
        input  req_in, mask, ack, ack_id,
        output Y, irq, overrun_cnt
    );
endinterface

// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - pending-interrupt latch with masking, ack handshake and overrun counter
// IRQ_EDGE_DETECT_EN selects rising-edge capture with overrun counting; undefined gives level capture.
module irq_pending_latch (
    input  logic                 clk,
    input  logic                 rst,
    irq_pending_latch_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_pending;
    logic [7:0] w_pending_next;
    logic [7:0] w_y;
    logic [7:0] w_set;
    logic [7:0] w_clr;
    logic       w_overrun;
    logic       r_irq;
    logic [3:0] r_overrun_cnt;

    assign w_y   = r_pending & ~bus.mask;
    assign w_clr = (r_state == S_ACTIVE && bus.ack) ? (8'd1 << bus.ack_id) : 8'd0;

`ifdef IRQ_EDGE_DETECT_EN
    logic [7:0] r_req_q;

    // Loaded during reset as well, so lines held high through reset raise no event.
    always_ff @(posedge clk) begin
        r_req_q <= bus.req_in;
    end

    assign w_set     = bus.req_in & ~r_req_q;
    assign w_overrun = |(w_set & r_pending & ~w_clr);
`else
    assign w_set     = bus.req_in;
    assign w_overrun = 1'b0;
`endif

    // Set wins over an ack-clear on the same bit.
    assign w_pending_next = (r_pending & ~w_clr) | w_set;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_y != 8'd0) begin
                    w_state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (bus.ack) begin
                    w_state_next = S_HOLDOFF;
                end else if (w_y == 8'd0) begin
                    w_state_next = S_IDLE;
                end
            end
            S_HOLDOFF: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending     <= 8'd0;
            r_overrun_cnt <= 4'd0;
            r_state       <= S_IDLE;
            r_irq         <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_state   <= w_state_next;
            r_irq     <= (w_state_next == S_ACTIVE);
            if (w_overrun && r_overrun_cnt != 4'd15) begin
                r_overrun_cnt <= r_overrun_cnt + 4'd1;
            end
        end
    end

    assign bus.Y           = w_y;
    assign bus.irq         = r_irq;
    assign bus.overrun_cnt = r_overrun_cnt;
endmodule

// File: tb/tb_irq_pending_latch.sv
// tb/tb_irq_pending_latch.sv - scoreboard bench for irq_pending_latch (edge or level build)
module tb_irq_pending_latch;
`ifdef IRQ_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] y;
        logic       irq;
        logic [3:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irq_pending_latch_if bus();

    irq_pending_latch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t       sb_q[$];
    logic [7:0] m_pend;
    logic [7:0] m_reqq;
    logic [3:0] m_cnt;
    int         m_st;
    int         n_cmp;
    int         n_err;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour for one rising edge, evaluated bit by bit.
    task automatic model_edge(input logic r, input logic [7:0] req, input logic [7:0] msk,
                              input logic a, input logic [2:0] aid);
        logic [7:0] np;
        logic       ovr;
        logic       set_b;
        logic       clr_b;
        if (r) begin
            m_pend = 8'd0;
            m_cnt  = 4'd0;
            m_st   = 0;
        end else begin
            ovr = 1'b0;
            np  = m_pend;
            for (int i = 0; i < 8; i++) begin
                set_b = EDGE ? (req[i] && !m_reqq[i]) : req[i];
                clr_b = (m_st == 1) && a && (int'(aid) == i);
                if (set_b && m_pend[i] && !clr_b) ovr = 1'b1;
                np[i] = set_b || (m_pend[i] && !clr_b);
            end
            case (m_st)
                0: if ((m_pend & ~msk) != 8'd0) m_st = 1;
                1: if (a) m_st = 2; else if ((m_pend & ~msk) == 8'd0) m_st = 0;
                default: m_st = 0;
            endcase
            m_pend = np;
            if (EDGE && ovr && m_cnt < 4'd15) m_cnt = m_cnt + 4'd1;
        end
        m_reqq = req;
    endtask

    task automatic step(input logic r, input logic [7:0] req, input logic [7:0] msk,
                        input logic a, input logic [2:0] aid);
        exp_t e;
        rst         = r;
        bus.req_in  = req;
        bus.mask    = msk;
        bus.ack     = a;
        bus.ack_id  = aid;
        model_edge(r, req, msk, a, aid);
        e.y   = m_pend & ~msk;
        e.irq = (m_st == 1);
        e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("sb_y", bus.Y, e.y);
        check_eq("sb_irq", {7'd0, bus.irq}, {7'd0, e.irq});
        check_eq("sb_cnt", {4'd0, bus.overrun_cnt}, {4'd0, e.cnt});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_pend = 8'd0;
        m_reqq = 8'd0;
        m_cnt  = 4'd0;
        m_st   = 0;
        rst = 1'b1;
        bus.req_in = 8'd0;
        bus.mask   = 8'd0;
        bus.ack    = 1'b0;
        bus.ack_id = 3'd0;
        @(posedge clk);
        #1;

        step(1, 8'h00, 8'h00, 0, 0);
        step(1, 8'h00, 8'h00, 0, 0);
        check_eq("rst_y", bus.Y, 8'h00);
        check_eq("rst_irq", {7'd0, bus.irq}, 8'h00);

        // Single request pulse, serviced
        step(0, 8'h04, 8'h00, 0, 0);
        check_eq("single_y", bus.Y, 8'h04);
        check_eq("single_irq_lo", {7'd0, bus.irq}, 8'h00);
        step(0, 8'h00, 8'h00, 0, 0);
        check_eq("single_irq_hi", {7'd0, bus.irq}, 8'h01);
        step(0, 8'h00, 8'h00, 1, 3'd2);
        check_eq("single_ack_y", bus.Y, 8'h00);
        check_eq("single_holdoff", {7'd0, bus.irq}, 8'h00);
        step(0, 8'h00, 8'h00, 0, 0);
        check_eq("single_idle", {7'd0, bus.irq}, 8'h00);

        // Two requests, serviced highest first
        step(0, 8'h81, 8'h00, 0, 0);
        check_eq("prio_y", bus.Y, 8'h81);
        step(0, 8'h00, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 1, 3'd7);
        check_eq("prio_y7", bus.Y, 8'h01);
        step(0, 8'h00, 8'h00, 0, 0);
        check_eq("prio_idle", {7'd0, bus.irq}, 8'h00);
        step(0, 8'h00, 8'h00, 0, 0);
        check_eq("prio_reassert", {7'd0, bus.irq}, 8'h01);
        step(0, 8'h00, 8'h00, 1, 3'd0);
        check_eq("prio_y0", bus.Y, 8'h00);
        step(0, 8'h00, 8'h00, 0, 0);

        // Masking withdraws and restores the request
        step(0, 8'h10, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 0, 0);
        bus.mask = 8'h10;
        #1;
        check_eq("mask_y_now", bus.Y, 8'h00);
        step(0, 8'h00, 8'h10, 0, 0);
        check_eq("mask_irq_drop", {7'd0, bus.irq}, 8'h00);
        step(0, 8'h00, 8'h10, 0, 0);
        bus.mask = 8'h00;
        #1;
        check_eq("unmask_y_now", bus.Y, 8'h10);
        step(0, 8'h00, 8'h00, 0, 0);
        check_eq("unmask_irq", {7'd0, bus.irq}, 8'h01);
        step(0, 8'h00, 8'h00, 1, 3'd4);
        step(0, 8'h00, 8'h00, 0, 0);

        // Set and ack-clear on the same bit
        step(0, 8'h08, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 0, 0);
        step(0, 8'h08, 8'h00, 1, 3'd3);
        check_eq("collide_y", bus.Y, 8'h08);
        check_eq("collide_holdoff", {7'd0, bus.irq}, 8'h00);
        step(0, 8'h00, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 1, 3'd3);
        step(0, 8'h00, 8'h00, 0, 0);

        // Repeated pulses on an already pending bit
        for (int k = 0; k < 20; k++) begin
            step(0, 8'h20, 8'h00, 0, 0);
            step(0, 8'h00, 8'h00, 0, 0);
        end
        check_eq("ovr_cnt", {4'd0, bus.overrun_cnt}, EDGE ? 8'd15 : 8'd0);
        check_eq("ovr_y", bus.Y, 8'h20);

        // Reset while active, with every line held high
        step(1, 8'hFF, 8'h00, 0, 0);
        check_eq("rstmid_y", bus.Y, 8'h00);
        check_eq("rstmid_irq", {7'd0, bus.irq}, 8'h00);
        for (int k = 0; k < 3; k++) step(0, 8'hFF, 8'h00, 0, 0);
        check_eq("rsthold_y", bus.Y, EDGE ? 8'h00 : 8'hFF);
        check_eq("rsthold_irq", {7'd0, bus.irq}, EDGE ? 8'h00 : 8'h01);

        // Random traffic against the reference
        step(1, 8'h00, 8'h00, 0, 0);
        for (int k = 0; k < 80; k++) begin
            step(0, 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                 ($urandom_range(0, 2) == 0), 3'($urandom));
        end
        step(1, 8'h00, 8'h00, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
